// File: rtl/sha_block_padder.sv
// Byte-stream to 512-bit SHA-2 message block padder.
// Packs bytes big-endian and appends 0x80, zero fill and the 64-bit bit length.
module sha_block_padder #(
  parameter int p_block_bits = 512,
  parameter int p_len_bits   = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [7:0]              in_data,
  input  logic                    in_last,
  input  logic                    in_keep,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [p_block_bits-1:0] out_block,
  output logic                    out_first,
  output logic                    out_last
);

  localparam int NB = p_block_bits / 8;
  localparam int LB = p_len_bits / 8;

  typedef enum logic [1:0] {
    S_ACCUM,
    S_PAD,
    S_LENBLK,
    S_EMIT
  } state_e;

  state_e                  state_q, state_d;
  state_e                  ret_q, ret_d;
  logic [p_block_bits-1:0] buf_q, buf_d;
  logic [5:0]              idx_q, idx_d;
  logic [p_len_bits-1:0]   len_q, len_d;
  logic                    pp_q, pp_d;
  logic                    first_q, first_d;
  logic                    final_q, final_d;

  logic accept;
  logic has_byte;

  assign in_ready  = (state_q == S_ACCUM) && !pp_q && !rst;
  assign accept    = in_valid && in_ready;
  assign has_byte  = in_keep || !in_last;
  assign out_valid = (state_q == S_EMIT);
  assign out_block = buf_q;
  assign out_first = out_valid && first_q;
  assign out_last  = out_valid && final_q;

  always_comb begin
    state_d = state_q;
    ret_d   = ret_q;
    buf_d   = buf_q;
    idx_d   = idx_q;
    len_d   = len_q;
    pp_d    = pp_q;
    first_d = first_q;
    final_d = final_q;
    unique case (state_q)
      S_ACCUM: begin
        if (pp_q) begin
          // message ended exactly on a block boundary
          state_d = S_PAD;
          pp_d    = 1'b0;
        end else if (accept) begin
          if (has_byte) begin
            for (int i = 0; i < NB; i++) begin
              if (6'(i) == idx_q)
                buf_d[8*(NB-1-i) +: 8] = in_data;
            end
            idx_d = idx_q + 6'd1;
            len_d = len_q + p_len_bits'(8);
            if (idx_q == 6'(NB-1)) begin
              state_d = S_EMIT;
              final_d = 1'b0;
              ret_d   = S_ACCUM;
              pp_d    = in_last;
            end else if (in_last) begin
              state_d = S_PAD;
            end
          end else begin
            state_d = S_PAD;
          end
        end
      end
      S_PAD: begin
        for (int i = 0; i < NB; i++) begin
          if (6'(i) == idx_q)
            buf_d[8*(NB-1-i) +: 8] = 8'h80;
          else if (6'(i) > idx_q)
            buf_d[8*(NB-1-i) +: 8] = 8'h00;
        end
        state_d = S_EMIT;
        if (idx_q <= 6'(NB-LB-1)) begin
          buf_d[p_len_bits-1:0] = len_q;
          final_d = 1'b1;
          ret_d   = S_ACCUM;
        end else begin
          final_d = 1'b0;
          ret_d   = S_LENBLK;
        end
      end
      S_LENBLK: begin
        buf_d                 = '0;
        buf_d[p_len_bits-1:0] = len_q;
        final_d               = 1'b1;
        state_d               = S_EMIT;
      end
      S_EMIT: begin
        if (out_ready) begin
          buf_d   = '0;
          idx_d   = '0;
          first_d = final_q;
          if (final_q) begin
            len_d   = '0;
            state_d = S_ACCUM;
          end else begin
            state_d = ret_q;
          end
        end
      end
      default: state_d = S_ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_ACCUM;
      ret_q   <= S_ACCUM;
      buf_q   <= '0;
      idx_q   <= '0;
      len_q   <= '0;
      pp_q    <= 1'b0;
      first_q <= 1'b1;
      final_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
      buf_q   <= buf_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      pp_q    <= pp_d;
      first_q <= first_d;
      final_q <= final_d;
    end
  end

endmodule

// File: tb/tb_sha_block_padder.sv
// Bench for sha_block_padder: byte-level padding model plus directed messages.
// Every emitted block is checked against the model each cycle it is valid.
module tb_sha_block_padder;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [7:0]   in_data;
  logic         in_last;
  logic         in_keep;
  logic         out_valid;
  logic         out_ready;
  logic [511:0] out_block;
  logic         out_first;
  logic         out_last;

  always #5 clk = ~clk;

  sha_block_padder dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_keep   (in_keep),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_block (out_block),
    .out_first (out_first),
    .out_last  (out_last)
  );

  typedef struct packed {
    logic [511:0] blk;
    logic         first;
    logic         last;
  } exp_t;

  localparam logic [511:0] ABC_BLK = {32'h61626380, 416'h0, 64'h18};

  int           checks = 0;
  int           errors = 0;
  exp_t         exp_q[$];
  logic [511:0] got_q[$];
  logic [7:0]   msg[$];
  logic [511:0] blk;

  task automatic chkb(input string nm, input logic [511:0] got,
                      input logic [511:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, got, want);
    end
  endtask

  task automatic chk1(input string nm, input logic got, input logic want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %b want %b", nm, got, want);
    end
  endtask

  task automatic chkn(input string nm, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got %0d want %0d", nm, got, want);
    end
  endtask

  function automatic logic [511:0] getb(input int k);
    if (got_q.size() > k) return got_q[k];
    return 'x;
  endfunction

  // Padding model: message ++ 0x80 ++ zeros to 56 mod 64 ++ 64-bit length.
  task automatic expect_msg();
    logic [7:0]  p[$];
    logic [63:0] bl;
    exp_t        e;
    int          nb;
    p = msg;
    p.push_back(8'h80);
    while (p.size() % 64 != 56) p.push_back(8'h00);
    bl = 64'(msg.size()) * 64'd8;
    for (int k = 7; k >= 0; k--) p.push_back(bl[8*k +: 8]);
    nb = p.size() / 64;
    for (int b = 0; b < nb; b++) begin
      e.blk = '0;
      for (int i = 0; i < 64; i++) e.blk[511-8*i -: 8] = p[64*b+i];
      e.first = (b == 0);
      e.last  = (b == nb - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic beat(input logic [7:0] d, input logic l, input logic k);
    bit acc = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    in_keep  = k;
    for (int t = 0; t < 200 && !acc; t++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
    end
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL beat_timeout got no accept want accept");
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_keep  = 1'b0;
  endtask

  task automatic send_msg();
    int n = msg.size();
    expect_msg();
    if (n == 0) beat(8'h00, 1'b1, 1'b0);
    for (int i = 0; i < n; i++)
      beat(msg[i], i == n - 1, (i == n - 1) ? 1'b1 : (i % 3 != 0));
  endtask

  task automatic drain(input string nm);
    for (int t = 0; t < 300 && exp_q.size() != 0; t++) @(posedge clk);
    #1;
    chkn(nm, exp_q.size(), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL extra_block got %0h want none", out_block);
      end else begin
        chkb("out_block", out_block, exp_q[0].blk);
        chk1("out_first", out_first, exp_q[0].first);
        chk1("out_last", out_last, exp_q[0].last);
        if (out_ready) begin
          got_q.push_back(out_block);
          void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    in_last   = 1'b0;
    in_keep   = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk1("rst_in_ready", in_ready, 1'b0);
    chk1("rst_out_valid", out_valid, 1'b0);
    chk1("rst_out_first", out_first, 1'b0);
    chk1("rst_out_last", out_last, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk1("idle_in_ready", in_ready, 1'b1);
    @(posedge clk);
    #1;

    // "abc" with latency through PAD
    msg = {8'h61, 8'h62, 8'h63};
    got_q.delete();
    expect_msg();
    beat(8'h61, 1'b0, 1'b1);
    beat(8'h62, 1'b0, 1'b0);
    beat(8'h63, 1'b1, 1'b1);
    chk1("abc_pad_cycle", out_valid, 1'b0);
    @(posedge clk);
    #1;
    chk1("abc_emit_cycle", out_valid, 1'b1);
    drain("abc_drain");
    chkn("abc_nblk", got_q.size(), 1);
    chkb("abc_literal", getb(0), ABC_BLK);

    // empty message
    msg.delete();
    got_q.delete();
    send_msg();
    drain("empty_drain");
    chkn("empty_nblk", got_q.size(), 1);
    chkb("empty_literal", getb(0), {8'h80, 504'h0});

    // 56 bytes: terminator lands in byte 56, length spills to a new block
    msg.delete();
    got_q.delete();
    for (int i = 0; i < 56; i++) msg.push_back(8'(i));
    send_msg();
    drain("m56_drain");
    chkn("m56_nblk", got_q.size(), 2);
    blk = getb(0);
    chkn("m56_byte56", 32'(blk[63:56]), 32'h80);
    chkb("m56_blk1", getb(1), 512'h1C0);

    // 64 bytes, last on byte 63
    msg.delete();
    got_q.delete();
    for (int i = 0; i < 64; i++) msg.push_back(8'(i * 3 + 1));
    expect_msg();
    for (int i = 0; i < 64; i++) beat(msg[i], i == 63, 1'b1);
    chk1("m64_latency", out_valid, 1'b1);
    drain("m64_drain");
    chkn("m64_nblk", got_q.size(), 2);
    chkb("m64_blk1", getb(1), {8'h80, 440'h0, 64'h200});

    // backpressure on "abc"
    out_ready = 1'b0;
    msg = {8'h61, 8'h62, 8'h63};
    got_q.delete();
    send_msg();
    for (int t = 0; t < 20 && !out_valid; t++) @(negedge clk);
    chk1("bp_valid", out_valid, 1'b1);
    in_valid = 1'b1;
    in_data  = 8'hEE;
    in_last  = 1'b1;
    in_keep  = 1'b1;
    repeat (10) begin
      @(negedge clk);
      chk1("bp_in_ready", in_ready, 1'b0);
      chk1("bp_hold_valid", out_valid, 1'b1);
    end
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk1("bp_accept", out_valid, 1'b0);
    drain("bp_drain");
    chkn("bp_nblk", got_q.size(), 1);
    chkb("bp_literal", getb(0), ABC_BLK);

    // reset mid-message discards partial data
    got_q.delete();
    for (int i = 0; i < 20; i++) beat(8'hA0 + 8'(i), 1'b0, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    chk1("mid_rst_in_ready", in_ready, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    msg = {8'h61, 8'h62, 8'h63};
    send_msg();
    drain("rst_drain");
    chkn("rst_nblk", got_q.size(), 1);
    chkb("rst_literal", getb(0), ABC_BLK);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
